// File: rtl/uart_cmd_sequencer_if.sv
// uart_cmd_sequencer_if: command word handshake bus (valid/ready, 3-bit code, 16-bit parameter).
//   master: drives cmd_valid, cmd_code, cmd_param; samples cmd_ready
//   slave : samples cmd_valid, cmd_code, cmd_param; drives cmd_ready
interface uart_cmd_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_code;
    logic [15:0] cmd_param;
    modport master (output cmd_valid, cmd_code, cmd_param, input cmd_ready);
    modport slave  (input cmd_valid, cmd_code, cmd_param, output cmd_ready);
endinterface

// File: rtl/uart_cmd_sequencer.sv
// uart_cmd_sequencer: assembles 5-byte UART frames (HEADER,CMD,PH,PL,CS), validates them and issues a command word.
//   clk_50M, rst_n (async, active-low)
//   rx_done, rx_byte         : byte strobe and data from the UART receiver
//   cmd (master modport)     : cmd_valid/cmd_ready handshake, cmd_code, cmd_param = {PH,PL}
//   frame_err, err_code      : one-cycle error pulse; 01 checksum, 10 bad command, 11 timeout (held)
//   overrun                  : one-cycle pulse when a byte arrives while a command is pending
//   busy, frame_cnt          : not-in-HUNT flag, count of issued frames (wraps)
//   Define CMD_TIMEOUT_EN to enable the inter-byte timeout (err_code 11).
module uart_cmd_sequencer #(
    parameter logic [7:0] HEADER         = 8'hAA,
    parameter int         MAX_CMD        = 7,
    parameter int         TIMEOUT_CYCLES = 50_000
) (
    input  logic                        clk_50M,
    input  logic                        rst_n,
    input  logic                        rx_done,
    input  logic [7:0]                  rx_byte,
    uart_cmd_sequencer_if.master        cmd,
    output logic                        frame_err,
    output logic [1:0]                  err_code,
    output logic                        overrun,
    output logic                        busy,
    output logic [7:0]                  frame_cnt
);
    localparam logic [2:0] S_HUNT  = 3'd0;
    localparam logic [2:0] S_CMD   = 3'd1;
    localparam logic [2:0] S_PH    = 3'd2;
    localparam logic [2:0] S_PL    = 3'd3;
    localparam logic [2:0] S_CS    = 3'd4;
    localparam logic [2:0] S_ISSUE = 3'd5;
    localparam logic [7:0] MAX_B   = 8'(MAX_CMD);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    logic [2:0] st, nxt;
    logic [7:0] cmd_b, ph_b, pl_b;
    logic       cs_bad, cmd_bad, to_hit, in_frame;

    assign in_frame = (st == S_CMD) || (st == S_PH) || (st == S_PL) || (st == S_CS);
    assign cs_bad   = rx_byte != (cmd_b ^ ph_b ^ pl_b);
    assign cmd_bad  = cmd_b > MAX_B;

`ifdef CMD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt;
    // a byte on the timeout edge wins: to_hit is masked by rx_done
    assign to_hit = in_frame && !rx_done && (to_cnt == TW'(TIMEOUT_CYCLES));
    // counts only while parked in a frame-collecting state; any state change (byte, error, entry) clears it
    always_ff @(posedge clk_50M or negedge rst_n)
        if (!rst_n) to_cnt <= '0;
        else        to_cnt <= (in_frame && nxt == st) ? to_cnt + 1'b1 : '0;
`else
    assign to_hit = 1'b0;
`endif

    always_comb begin
        nxt = st;
        case (st)
            S_HUNT:  nxt = (rx_done && rx_byte == HEADER) ? S_CMD : S_HUNT;
            S_CMD:   nxt = rx_done ? S_PH : to_hit ? S_HUNT : S_CMD;
            S_PH:    nxt = rx_done ? S_PL : to_hit ? S_HUNT : S_PH;
            S_PL:    nxt = rx_done ? S_CS : to_hit ? S_HUNT : S_PL;
            S_CS:    nxt = rx_done ? ((cs_bad || cmd_bad) ? S_HUNT : S_ISSUE) : to_hit ? S_HUNT : S_CS;
            S_ISSUE: nxt = cmd.cmd_ready ? S_HUNT : S_ISSUE;
            default: nxt = S_HUNT;
        endcase
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            st            <= S_HUNT;
            cmd_b         <= '0;
            ph_b          <= '0;
            pl_b          <= '0;
            cmd.cmd_valid <= 1'b0;
            cmd.cmd_code  <= '0;
            cmd.cmd_param <= '0;
            frame_err     <= 1'b0;
            err_code      <= '0;
            overrun       <= 1'b0;
            busy          <= 1'b0;
            frame_cnt     <= '0;
        end else begin
            st        <= nxt;
            busy      <= nxt != S_HUNT;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (rx_done && st == S_CMD) cmd_b <= rx_byte;
            if (rx_done && st == S_PH)  ph_b  <= rx_byte;
            if (rx_done && st == S_PL)  pl_b  <= rx_byte;
            if (rx_done && st == S_CS) begin
                if (cs_bad) begin
                    frame_err <= 1'b1;
                    err_code  <= 2'b01;
                end else if (cmd_bad) begin
                    frame_err <= 1'b1;
                    err_code  <= 2'b10;
                end else begin
                    cmd.cmd_valid <= 1'b1;
                    cmd.cmd_code  <= cmd_b[2:0];
                    cmd.cmd_param <= {ph_b, pl_b};
                end
            end
            if (to_hit) begin
                frame_err <= 1'b1;
                err_code  <= 2'b11;
            end
            // bytes arriving while a command is pending are dropped, including on the handshake edge
            if (st == S_ISSUE) begin
                overrun <= rx_done;
                if (cmd.cmd_ready) begin
                    cmd.cmd_valid <= 1'b0;
                    frame_cnt     <= frame_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// tb_uart_cmd_sequencer: directed self-checking bench for uart_cmd_sequencer.
module tb_uart_cmd_sequencer;
    localparam int TO = 20;

    logic        clk_50M = 1'b0;
    logic        rst_n   = 1'b0;
    logic        rx_done = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        frame_err, overrun, busy;
    logic [1:0]  err_code;
    logic [7:0]  frame_cnt;
    int          passed = 0;
    int          total  = 0;
    int          exp_cnt = 0;

    uart_cmd_sequencer_if cif ();

    uart_cmd_sequencer #(.HEADER(8'hAA), .MAX_CMD(7), .TIMEOUT_CYCLES(TO)) dut (
        .clk_50M   (clk_50M),
        .rst_n     (rst_n),
        .rx_done   (rx_done),
        .rx_byte   (rx_byte),
        .cmd       (cif.master),
        .frame_err (frame_err),
        .err_code  (err_code),
        .overrun   (overrun),
        .busy      (busy),
        .frame_cnt (frame_cnt)
    );

    always #10 clk_50M = ~clk_50M;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk_50M);
        rx_done = 1'b1;
        rx_byte = b;
        @(negedge clk_50M);
        rx_done = 1'b0;
    endtask

    // back-to-back strobes; returns on the negedge after the last byte was sampled
    task automatic send_frame(input logic [7:0] b0, b1, b2, b3, b4);
        logic [7:0] f [5];
        f = '{b0, b1, b2, b3, b4};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_50M);
            rx_done = 1'b1;
            rx_byte = f[i];
        end
        @(negedge clk_50M);
        rx_done = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, 32'(cif.cmd_valid), 0);
        chk({tag, "_code"},  32'(cif.cmd_code), 0);
        chk({tag, "_param"}, 32'(cif.cmd_param), 0);
        chk({tag, "_ferr"},  32'(frame_err), 0);
        chk({tag, "_ecode"}, 32'(err_code), 0);
        chk({tag, "_ovr"},   32'(overrun), 0);
        chk({tag, "_busy"},  32'(busy), 0);
        chk({tag, "_cnt"},   32'(frame_cnt), 0);
    endtask

    initial begin
        bit seen;
        cif.cmd_ready = 1'b1;
        repeat (2) @(negedge clk_50M);
        chk_zero("reset");
        rst_n = 1'b1;

        send_frame(8'hAA, 8'h03, 8'h12, 8'h34, 8'h25);
        chk("good_valid", 32'(cif.cmd_valid), 1);
        chk("good_code",  32'(cif.cmd_code), 3);
        chk("good_param", 32'(cif.cmd_param), 32'h1234);
        chk("good_busy",  32'(busy), 1);
        chk("good_cnt0",  32'(frame_cnt), 0);
        @(negedge clk_50M);
        exp_cnt++;
        chk("good_valid_drop", 32'(cif.cmd_valid), 0);
        chk("good_cnt1",  32'(frame_cnt), 32'(exp_cnt));
        chk("good_idle",  32'(busy), 0);

        send_frame(8'hAA, 8'h03, 8'h12, 8'h34, 8'h00);
        chk("cs_ferr",  32'(frame_err), 1);
        chk("cs_ecode", 32'(err_code), 1);
        chk("cs_valid", 32'(cif.cmd_valid), 0);
        chk("cs_busy",  32'(busy), 0);
        @(negedge clk_50M);
        chk("cs_ferr_pulse", 32'(frame_err), 0);
        chk("cs_ecode_held", 32'(err_code), 1);

        send_frame(8'hAA, 8'h01, 8'h00, 8'h00, 8'h01);
        chk("rec_valid", 32'(cif.cmd_valid), 1);
        chk("rec_code",  32'(cif.cmd_code), 1);
        chk("rec_param", 32'(cif.cmd_param), 0);
        @(negedge clk_50M);
        exp_cnt++;
        chk("rec_cnt", 32'(frame_cnt), 32'(exp_cnt));

        send_frame(8'hAA, 8'h09, 8'h00, 8'h00, 8'h09);
        chk("badcmd_ferr",  32'(frame_err), 1);
        chk("badcmd_ecode", 32'(err_code), 2);
        chk("badcmd_valid", 32'(cif.cmd_valid), 0);
        send_byte(8'h55);
        chk("garbage_busy",  32'(busy), 0);
        chk("garbage_ferr",  32'(frame_err), 0);
        chk("garbage_ecode", 32'(err_code), 2);

        cif.cmd_ready = 1'b0;
        send_frame(8'hAA, 8'h05, 8'hAB, 8'hCD, 8'h63);
        chk("bp_valid", 32'(cif.cmd_valid), 1);
        chk("bp_code",  32'(cif.cmd_code), 5);
        chk("bp_param", 32'(cif.cmd_param), 32'hABCD);
        repeat (10) @(negedge clk_50M);
        send_byte(8'h77);
        chk("bp_ovr",       32'(overrun), 1);
        chk("bp_ovr_noerr", 32'(frame_err), 0);
        @(negedge clk_50M);
        chk("bp_ovr_pulse", 32'(overrun), 0);
        repeat (85) @(negedge clk_50M);
        chk("bp_hold_valid", 32'(cif.cmd_valid), 1);
        chk("bp_hold_code",  32'(cif.cmd_code), 5);
        chk("bp_hold_param", 32'(cif.cmd_param), 32'hABCD);
        chk("bp_hold_cnt",   32'(frame_cnt), 32'(exp_cnt));
        cif.cmd_ready = 1'b1;
        rx_done = 1'b1;
        rx_byte = 8'hAA;
        @(negedge clk_50M);
        rx_done = 1'b0;
        exp_cnt++;
        chk("hs_valid",  32'(cif.cmd_valid), 0);
        chk("hs_cnt",    32'(frame_cnt), 32'(exp_cnt));
        chk("hs_hdr_ovr", 32'(overrun), 1);
        chk("hs_busy",   32'(busy), 0);

        send_frame(8'hAA, 8'h00, 8'hAA, 8'hAA, 8'h00);
        chk("hdr_data_valid", 32'(cif.cmd_valid), 1);
        chk("hdr_data_param", 32'(cif.cmd_param), 32'hAAAA);
        @(negedge clk_50M);
        exp_cnt++;
        chk("hdr_data_cnt", 32'(frame_cnt), 32'(exp_cnt));

        send_byte(8'hAA);
        send_byte(8'h02);
        seen = 1'b0;
        for (int i = 0; i < 3 * TO && !seen; i++) begin
            @(negedge clk_50M);
            seen = frame_err;
        end
`ifdef CMD_TIMEOUT_EN
        chk("to_ferr",  32'(seen), 1);
        chk("to_ecode", 32'(err_code), 3);
        chk("to_busy",  32'(busy), 0);
`else
        chk("noto_ferr",  32'(seen), 0);
        chk("noto_busy",  32'(busy), 1);
        chk("noto_ecode", 32'(err_code), 2);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h24);
        chk("noto_valid", 32'(cif.cmd_valid), 1);
        chk("noto_code",  32'(cif.cmd_code), 2);
        @(negedge clk_50M);
        exp_cnt++;
        chk("noto_cnt", 32'(frame_cnt), 32'(exp_cnt));
`endif

        cif.cmd_ready = 1'b0;
        send_frame(8'hAA, 8'h07, 8'h01, 8'h02, 8'h04);
        chk("pre_rst_valid", 32'(cif.cmd_valid), 1);
        rst_n = 1'b0;
        #1;
        chk_zero("rst_issue");
        @(negedge clk_50M);
        rst_n = 1'b1;
        cif.cmd_ready = 1'b1;
        @(negedge clk_50M);
        chk("post_rst_valid", 32'(cif.cmd_valid), 0);
        chk("post_rst_busy",  32'(busy), 0);

        for (int n = 0; n < 256; n++) send_frame(8'hAA, 8'h01, 8'h00, 8'h00, 8'h01);
        @(negedge clk_50M);
        chk("wrap_cnt", 32'(frame_cnt), 0);
        send_frame(8'hAA, 8'h06, 8'hFF, 8'h00, 8'hF9);
        chk("wrap_code", 32'(cif.cmd_code), 6);
        @(negedge clk_50M);
        chk("wrap_cnt1", 32'(frame_cnt), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
